mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data RAM between the pipelined CPU's IF stage and MEM stage.
- Grants the RAM to one requester at a time and sequences fixed-latency RAM accesses.
- Raises stall_o to freeze PC and all pipeline registers until every access requested in the current pipeline cycle has completed.
- Sits between the CPU pipeline, the Hazard_Detection stall path and the RAM macro.

Parameters:
LATENCY, 2, cycles the RAM needs per access (ram_rdata_i valid in the LATENCY-th cycle of ram_en_o); legal range 1..15.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
if_req_i  in  1  fetch request; level, held stable while stall_o=1
if_addr_i  in  32  fetch byte address (PC)
if_rdata_o  out  32  fetched instruction; registered
if_ready_o  out  1  fetch of current pipeline cycle complete (if_done flag)
mem_req_i  in  1  data request (MemRead|MemWrite); level, held while stall_o=1
mem_we_i  in  1  1=store, 0=load
mem_addr_i  in  32  data byte address
mem_wdata_i  in  32  store data
mem_rdata_o  out  32  load data; registered
mem_ready_o  out  1  data access of current pipeline cycle complete (mem_done flag)
stall_o  out  1  freeze PC and IF/ID, ID/EX, EX/MEM, MEM/WB
ram_en_o  out  1  RAM access enable
ram_we_o  out  1  RAM write enable
ram_addr_o  out  32  RAM byte address; passed through unchanged, alignment is the requester's responsibility
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data
stall_cnt_o  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Internal state: mem_done, if_done flags; access-cycle counter cnt (4 bits); if_rdata/mem_rdata registers.
- Pending signals: mem_pend = mem_req_i & ~mem_done; if_pend = if_req_i & ~if_done.
- Grant (combinational, fixed priority, data before fetch because the MEM-stage instruction is older): sel = DATA if mem_pend, else INST if if_pend, else NONE.
- Derived states: IDLE (no request), DACC (sel=DATA), IACC (sel=INST), DONE (requests present, all done).
- RAM drive:
  - ram_en_o = (sel != NONE).
  - ram_addr_o = granted address; 0 when NONE.
  - ram_we_o = (sel=DATA) & mem_we_i.
  - ram_wdata_o = mem_wdata_i when sel=DATA, else 0.
- Counter: each edge with sel != NONE and cnt < LATENCY-1: cnt <= cnt+1.
- Completion: at the edge with cnt == LATENCY-1:
  - cnt <= 0.
  - Set the granted done flag.
  - Load: mem_rdata_o <= ram_rdata_i.
  - Fetch: if_rdata_o <= ram_rdata_i.
  - Store: mem_rdata_o unchanged.
- Back-to-back: the next pending access starts the cycle after completion (DACC -> IACC, no idle gap).
- stall_o = mem_pend | if_pend (combinational). Pipeline advances on an edge with stall_o=0.
- At any edge with stall_o=0, both done flags clear, so the next instruction's requests are serviced fresh.
- Stall cost per pipeline cycle = LATENCY × (number of requested accesses).
- Request dropped mid-access (e.g. flush removes mem_req_i): sel changes immediately and cnt resets to 0 at the next edge. The partial access is abandoned with no data captured. A store abandoned before completion has no architectural guarantee.
- Requests constant 0: IDLE, stall_o=0, ram_en_o=0.
- Reset (asynchronous, any time, including mid-access):
  - cnt=0, flags=0, if_rdata_o=0, mem_rdata_o=0, stall_cnt_o=0.
  - ram_en_o/ram_we_o follow from the cleared state and the current requests.
  - After release, any access restarts from cycle 1.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: stall_cnt_o increments by 1 on every rising edge where stall_o=1 and rst_i=0; saturates at 0xFFFFFFFF. Used by the bench's stall accounting.
- Undefined: the counter logic is omitted and stall_cnt_o is tied to 0.

Test Plan:
1. rst_i=1 with if_req_i=0, mem_req_i=0 -> if_rdata_o=0, mem_rdata_o=0, ready outputs 0, ram_en_o=0, stall_o=0.
2. LATENCY=2, lone fetch at 0x00000008, RAM returns 0x20080005 -> ram_en_o=1 for 2 cycles; stall_o 1,1,0; 3rd cycle if_ready_o=1, if_rdata_o=0x20080005; flags clear at next edge.
3. LATENCY=1, simultaneous load from 0x0 (RAM returns 5) and fetch from 0x10 -> cycle0 ram_addr_o=0x0, cycle1 ram_addr_o=0x10; stall_o 1,1,0; mem_rdata_o=5.
4. LATENCY=2, store 0x000000AB to 0x4 -> ram_we_o=1 for exactly 2 cycles with ram_wdata_o=0xAB; mem_rdata_o holds its previous value.
5. LATENCY=3, rst_i pulsed asynchronously during cycle 2 of a load -> flags/cnt cleared immediately; after release the load takes 3 full cycles again.
6. ARB_PERF_CNT_EN defined, LATENCY=2, 4 instructions each with fetch+load -> stall_cnt_o=16; same run without the macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified RAM between the IF and MEM
// pipeline stages. Data accesses take priority over fetches. stall_o holds the
// pipeline until every access requested this pipeline cycle has completed.
// Optional build macro: ARB_PERF_CNT_EN enables the saturating stall-cycle counter.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        stall_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {SelNone, SelData, SelInst} sel_t;

    localparam logic [3:0] LastCnt = 4'(LATENCY - 1);

    logic        mem_done_q, if_done_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_eff;
    sel_t        sel, sel_q;
    logic        mem_pend, if_pend;
    logic        last;

    // Grant, completion detect and RAM drive
    always_comb begin
        mem_pend = mem_req_i & ~mem_done_q;
        if_pend  = if_req_i & ~if_done_q;
        if (mem_pend) begin
            sel = SelData;
        end else if (if_pend) begin
            sel = SelInst;
        end else begin
            sel = SelNone;
        end
        // A grant that differs from last cycle's owner starts from cycle 1,
        // which abandons any partial access by the previous owner.
        cnt_eff     = (sel == sel_q) ? cnt_q : 4'd0;
        last        = (sel != SelNone) && (cnt_eff == LastCnt);
        stall_o     = mem_pend | if_pend;
        ram_en_o    = (sel != SelNone);
        ram_we_o    = (sel == SelData) & mem_we_i;
        ram_addr_o  = 32'd0;
        ram_wdata_o = 32'd0;
        if (sel == SelData) begin
            ram_addr_o  = mem_addr_i;
            ram_wdata_o = mem_wdata_i;
        end else if (sel == SelInst) begin
            ram_addr_o  = if_addr_i;
        end
    end

    // Access counter, done flags and read-data capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q       <= SelNone;
            cnt_q       <= 4'd0;
            mem_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
            if_rdata_o  <= 32'd0;
            mem_rdata_o <= 32'd0;
        end else begin
            sel_q <= sel;
            if (sel == SelNone || last) begin
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_eff + 4'd1;
            end
            if (!stall_o) begin
                // Pipeline advances: next instruction's requests start fresh
                mem_done_q <= 1'b0;
                if_done_q  <= 1'b0;
            end else if (last) begin
                if (sel == SelData) begin
                    mem_done_q <= 1'b1;
                    if (!mem_we_i) begin
                        mem_rdata_o <= ram_rdata_i;
                    end
                end else begin
                    if_done_q  <= 1'b1;
                    if_rdata_o <= ram_rdata_i;
                end
            end
        end
    end

    assign if_ready_o  = if_done_q;
    assign mem_ready_o = mem_done_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances with LATENCY 2, 1 and 3
// run independent directed sequences; the RAM is modelled as an address lookup.
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic [31:0] if_rdata  [N];
    logic        if_ready  [N];
    logic        mem_req   [N];
    logic        mem_we    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        mem_ready [N];
    logic        stall     [N];
    logic        ram_en    [N];
    logic        ram_we    [N];
    logic [31:0] ram_addr  [N];
    logic [31:0] ram_wdata [N];
    logic [31:0] ram_rdata [N];
    logic [31:0] stall_cnt [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: LATENCY=2, 1: LATENCY=1, 2: LATENCY=3
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        mem_port_arbiter #(.LATENCY(L)) dut (
            .clk_i      (clk),
            .rst_i      (rst[g]),
            .if_req_i   (if_req[g]),
            .if_addr_i  (if_addr[g]),
            .if_rdata_o (if_rdata[g]),
            .if_ready_o (if_ready[g]),
            .mem_req_i  (mem_req[g]),
            .mem_we_i   (mem_we[g]),
            .mem_addr_i (mem_addr[g]),
            .mem_wdata_i(mem_wdata[g]),
            .mem_rdata_o(mem_rdata[g]),
            .mem_ready_o(mem_ready[g]),
            .stall_o    (stall[g]),
            .ram_en_o   (ram_en[g]),
            .ram_we_o   (ram_we[g]),
            .ram_addr_o (ram_addr[g]),
            .ram_wdata_o(ram_wdata[g]),
            .ram_rdata_i(ram_rdata[g]),
            .stall_cnt_o(stall_cnt[g])
        );
    end

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0005;
            32'h8:   return 32'h2008_0005;
            32'h10:  return 32'h8C01_0000;
            default: return 32'hDEAD_0000 | a;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) ram_rdata[i] = ram_word(ram_addr[i]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs driven here)
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int n;
    logic [31:0] exp_cnt;

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = '0;
            mem_req[i] = 1'b0; mem_we[i] = 1'b0; mem_addr[i] = '0; mem_wdata[i] = '0;
        end
        tick(); tick(); #1;

        // 1: reset state
        chk("rst_if_rdata", if_rdata[0], 32'h0);
        chk("rst_mem_rdata", mem_rdata[0], 32'h0);
        chk("rst_if_ready", {31'd0, if_ready[0]}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready[0]}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en[0]}, 32'd0);
        chk("rst_stall", {31'd0, stall[0]}, 32'd0);
        chk("rst_stall_cnt", stall_cnt[0], 32'd0);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        tick(); #1;
        chk("idle_ram_en", {31'd0, ram_en[1]}, 32'd0);
        chk("idle_stall", {31'd0, stall[1]}, 32'd0);

        // 2: LATENCY=2 lone fetch from 0x8
        if_req[0] = 1'b1; if_addr[0] = 32'h8;
        #1;
        chk("f_c0_en", {31'd0, ram_en[0]}, 32'd1);
        chk("f_c0_addr", ram_addr[0], 32'h8);
        chk("f_c0_stall", {31'd0, stall[0]}, 32'd1);
        tick(); #1;
        chk("f_c1_en", {31'd0, ram_en[0]}, 32'd1);
        chk("f_c1_stall", {31'd0, stall[0]}, 32'd1);
        chk("f_c1_ready", {31'd0, if_ready[0]}, 32'd0);
        tick(); #1;
        chk("f_c2_stall", {31'd0, stall[0]}, 32'd0);
        chk("f_c2_en", {31'd0, ram_en[0]}, 32'd0);
        chk("f_c2_ready", {31'd0, if_ready[0]}, 32'd1);
        chk("f_c2_rdata", if_rdata[0], 32'h2008_0005);
        if_req[0] = 1'b0;
        tick(); #1;
        chk("f_clr_ready", {31'd0, if_ready[0]}, 32'd0);
        chk("f_hold_rdata", if_rdata[0], 32'h2008_0005);

        // 3: LATENCY=1 load from 0x0 plus fetch from 0x10
        mem_req[1] = 1'b1; mem_addr[1] = 32'h0; if_req[1] = 1'b1; if_addr[1] = 32'h10;
        #1;
        chk("lf_c0_addr", ram_addr[1], 32'h0);
        chk("lf_c0_we", {31'd0, ram_we[1]}, 32'd0);
        chk("lf_c0_stall", {31'd0, stall[1]}, 32'd1);
        tick(); #1;
        chk("lf_c1_addr", ram_addr[1], 32'h10);
        chk("lf_c1_stall", {31'd0, stall[1]}, 32'd1);
        chk("lf_c1_mready", {31'd0, mem_ready[1]}, 32'd1);
        tick(); #1;
        chk("lf_c2_stall", {31'd0, stall[1]}, 32'd0);
        chk("lf_c2_mrdata", mem_rdata[1], 32'h5);
        chk("lf_c2_irdata", if_rdata[1], 32'h8C01_0000);
        mem_req[1] = 1'b0; if_req[1] = 1'b0;

        // 4: LATENCY=2 load 0x0 then store 0xAB to 0x4; store leaves mem_rdata alone
        mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h0;
        tick(); tick(); #1;
        chk("ld_rdata", mem_rdata[0], 32'h5);
        mem_req[0] = 1'b0;
        tick();
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 32'h4; mem_wdata[0] = 32'hAB;
        #1;
        chk("st_c0_we", {31'd0, ram_we[0]}, 32'd1);
        chk("st_c0_wdata", ram_wdata[0], 32'hAB);
        chk("st_c0_addr", ram_addr[0], 32'h4);
        tick(); #1;
        chk("st_c1_we", {31'd0, ram_we[0]}, 32'd1);
        chk("st_c1_wdata", ram_wdata[0], 32'hAB);
        tick(); #1;
        chk("st_c2_we", {31'd0, ram_we[0]}, 32'd0);
        chk("st_c2_ready", {31'd0, mem_ready[0]}, 32'd1);
        chk("st_c2_rdata", mem_rdata[0], 32'h5);
        mem_req[0] = 1'b0; mem_we[0] = 1'b0;

        // 5: LATENCY=3 load from 0x8, async reset during its 2nd cycle
        mem_req[2] = 1'b1; mem_addr[2] = 32'h8;
        tick(); #1;
        rst[2] = 1'b1;
        #1;
        chk("ar_ready", {31'd0, mem_ready[2]}, 32'd0);
        chk("ar_en", {31'd0, ram_en[2]}, 32'd1);
        chk("ar_stall", {31'd0, stall[2]}, 32'd1);
        #1;
        rst[2] = 1'b0;
        tick(); #1;
        chk("ar_r1_ready", {31'd0, mem_ready[2]}, 32'd0);
        tick(); #1;
        chk("ar_r2_ready", {31'd0, mem_ready[2]}, 32'd0);
        chk("ar_r2_stall", {31'd0, stall[2]}, 32'd1);
        tick(); #1;
        chk("ar_r3_ready", {31'd0, mem_ready[2]}, 32'd1);
        chk("ar_r3_rdata", mem_rdata[2], 32'h2008_0005);
        chk("ar_r3_stall", {31'd0, stall[2]}, 32'd0);
        mem_req[2] = 1'b0;

        // 6: LATENCY=2, four instructions each with fetch+load; 4 stall cycles each
        rst[0] = 1'b1;
        #1;
        rst[0] = 1'b0;
        tick();
        if_req[0] = 1'b1; if_addr[0] = 32'h10; mem_req[0] = 1'b1; mem_addr[0] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (stall[0] && n < 20) begin
                n++;
                tick(); #1;
            end
            chk($sformatf("pc_stall_len%0d", k), n, 32'd4);
            tick();
        end
        if_req[0] = 1'b0; mem_req[0] = 1'b0;
        tick(); #1;
`ifdef ARB_PERF_CNT_EN
        exp_cnt = 32'd16;
`else
        exp_cnt = 32'd0;
`endif
        chk("pc_stall_cnt", stall_cnt[0], exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
